button_input_unit: RTL and testbench
====================================

// Module: button_input_unit
// PURPOSE
//  Player-input front end for the Simon game: the input-side counterpart of the
//  seven-segment display driver. Synchronises and debounces the raw board push-buttons,
//  detects presses, and hands each press to the game FSM over a valid/ready interface.
//  Presses are accepted only while the game enables player input (the player's turn).
// PARAMETERS
//  N_BTN        4        number of push-buttons (index 0..N_BTN-1)
//  IDX_W        2        width of press_idx; must satisfy 2**IDX_W >= N_BTN
//  SAMPLE_DIV   100_000  clk cycles per debounce sample tick (1 ms at 100 MHz)
//  STABLE_TICKS 10       consecutive ticks a new level must hold to be accepted
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      asynchronous reset, active-high
//  btn_raw      in   N_BTN  raw buttons, asynchronous, 1 = pressed
//  accept_en    in   1      1 = player turn, presses may be queued
//  press_ready  in   1      game FSM consumes press this cycle when press_valid=1
//  press_valid  out  1      a press event is pending
//  press_idx    out  IDX_W  index of the pending press; held stable while valid
//  btn_level    out  N_BTN  debounced button levels
//  overflow     out  1      sticky: a press was dropped (slot busy or multi-press)
//  ovf_clr      in   1      synchronous clear of overflow
// BEHAVIOUR
//  Reset (async, immediate): sync flops, btn_level, press_valid, press_idx, overflow,
//   tick divider, and all stable counters = 0.
//  Sync: 2-flop synchroniser per button; synced value s[i] lags btn_raw by 2 clk.
//  Tick: divider counts 0..SAMPLE_DIV-1; tick=1 for one clk when it wraps to 0.
//  Debounce per button, evaluated only on tick:
//   - s[i]==btn_level[i]: cnt[i] <= 0.
//   - s[i]!=btn_level[i] and cnt[i]==STABLE_TICKS-1: btn_level[i] <= s[i], cnt[i] <= 0.
//   - otherwise: cnt[i] <= cnt[i]+1. A glitch shorter than STABLE_TICKS ticks never
//     reaches btn_level. Release is debounced identically.
//  Press event: rise[i] = btn_level[i] rose this clk (registered edge detect);
//   press visible on press_valid exactly 1 clk after btn_level rises.
//  Event slot (one entry):
//   - Handshake: transfer when press_valid && press_ready; slot empties next clk.
//     press_valid/press_idx are not changed by the unit while pending and unaccepted.
//   - New rise with accept_en=1 and slot empty (or emptying this clk): load
//     press_idx = lowest set index of rise, press_valid <= 1.
//   - More than one rise bit in the same clk: lowest index loads, overflow <= 1.
//   - Rise while slot full and not emptying: press dropped, overflow <= 1.
//   - Rise with accept_en=0: silently ignored, no overflow. accept_en does not
//     flush a pending press.
//   - ovf_clr and a new overflow in the same clk: overflow stays 1 (set wins).
//  Button held through a turn change produces no press; only a new rise counts.
//  rst asserted mid-debounce or with a press pending: everything returns to reset
//   values; pending press is lost; a button still held after reset release is
//   debounced as a new press (btn_level rises from 0).
// TESTING  (SAMPLE_DIV=4, STABLE_TICKS=3)
//  1 btn_raw[2] 0->1 held, accept_en=1, press_ready=0 -> btn_level[2]=1 after 3 ticks
//    (<=12 clk + sync), press_valid=1 next clk with press_idx=2, held until ready=1.
//  2 btn_raw[1] pulses high for 2 ticks then low -> btn_level stays 0, no press_valid.
//  3 press 0 pending, ready=0, then press 3 -> press_idx stays 0, overflow=1;
//    ovf_clr=1 -> overflow=0.
//  4 btn_raw[1] and [3] rise in the same clk -> press_idx=1, overflow=1.
//  5 accept_en=0 during press of btn 0 -> press_valid stays 0, overflow stays 0.
//  6 rst pulsed while press_valid=1 and btn 2 held -> all outputs 0 immediately;
//    after release btn 2 re-debounces and yields press_idx=2.

Source files
------------

// File: rtl/button_input_unit.sv
// button_input_unit: synchronises and debounces the board push-buttons, turns each
// debounced press into an event, and offers it to the game FSM through a one-entry slot.
//
// Handshake: press_valid/press_idx describe the pending press. A transfer happens on a
// rising clk edge where press_valid && press_ready. Once press_valid is raised, the unit
// holds press_valid and press_idx unchanged until that transfer. A new press may load on
// the same edge that the current one transfers.
module button_input_unit #(
    parameter int N_BTN        = 4,
    parameter int IDX_W        = 2,
    parameter int SAMPLE_DIV   = 100_000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             accept_en,
    input  logic             press_ready,
    output logic             press_valid,
    output logic [IDX_W-1:0] press_idx,
    output logic [N_BTN-1:0] btn_level,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    logic [N_BTN-1:0] sync1, sync2;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [CNT_W-1:0] cnt [N_BTN];
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] rise;
    logic             any_rise;
    logic             multi_rise;
    logic [IDX_W-1:0] low_idx;
    logic             slot_free;
    logic             load;
    logic             ovf_set;

    // Two-flop synchroniser on the asynchronous button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Sample-tick divider: counts 0..SAMPLE_DIV-1, tick marks the wrap cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    // Per-button debounce: a new level must persist for STABLE_TICKS ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(STABLE_TICKS - 1)) begin
                    btn_level[i] <= sync2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Previous debounced level, for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= btn_level;
        end
    end

    assign rise       = btn_level & ~level_q;
    assign any_rise   = |rise;
    assign multi_rise = |(rise & (rise - N_BTN'(1)));

    // Priority encoder: lowest rising button index wins.
    always_comb begin
        low_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (rise[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign slot_free = !press_valid || press_ready;
    assign load      = accept_en && any_rise && slot_free;
    assign ovf_set   = accept_en && any_rise && (multi_rise || !slot_free);

    // Event slot and sticky overflow flag; a new overflow beats ovf_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_valid <= 1'b0;
            press_idx   <= '0;
            overflow    <= 1'b0;
        end else begin
            if (press_valid && press_ready) begin
                press_valid <= 1'b0;
            end
            if (load) begin
                press_valid <= 1'b1;
                press_idx   <= low_idx;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_input_unit.sv
// Directed bench for button_input_unit with a short tick (SAMPLE_DIV=4, STABLE_TICKS=3).
module tb_button_input_unit;

    logic       clk;
    logic       rst;
    logic [3:0] btn_raw;
    logic       accept_en;
    logic       press_ready;
    logic       press_valid;
    logic [1:0] press_idx;
    logic [3:0] btn_level;
    logic       overflow;
    logic       ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    button_input_unit #(
        .N_BTN(4), .IDX_W(2), .SAMPLE_DIV(4), .STABLE_TICKS(3)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .accept_en(accept_en),
        .press_ready(press_ready), .press_valid(press_valid), .press_idx(press_idx),
        .btn_level(btn_level), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) until btn_level equals lvl; sampled on falling edges.
    task automatic wait_level(input logic [3:0] lvl, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (btn_level === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) @(negedge clk);
    endtask

    // One-cycle consume of the pending press
    task automatic consume();
        press_ready = 1'b1;
        @(negedge clk);
        press_ready = 1'b0;
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_raw = '0; accept_en = 1'b1; press_ready = 1'b0; ovf_clr = 1'b0;
        idle(3);
        n_checks++;
        if ({press_valid, press_idx, btn_level, overflow} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {press_valid, press_idx, btn_level, overflow});
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_single_press();
        bit ok;
        btn_raw = 4'b0100;
        wait_level(4'b0100, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL press_level_timeout: got %b expected 0100", btn_level); end
        n_checks++;
        if (press_valid !== 1'b0) begin n_fail++; $display("FAIL press_latency_early: got %b expected 0", press_valid); end
        @(negedge clk);
        n_checks++;
        if (press_valid !== 1'b1 || press_idx !== 2'd2) begin
            n_fail++; $display("FAIL press_valid_idx: got v=%b idx=%0d expected v=1 idx=2", press_valid, press_idx);
        end
        idle(6);
        n_checks++;
        if (press_valid !== 1'b1 || press_idx !== 2'd2) begin
            n_fail++; $display("FAIL press_hold: got v=%b idx=%0d expected v=1 idx=2", press_valid, press_idx);
        end
        consume();
        n_checks++;
        if (press_valid !== 1'b0) begin n_fail++; $display("FAIL press_consumed: got %b expected 0", press_valid); end
        btn_raw = 4'b0000;
        wait_level(4'b0000, ok);
        n_checks++;
        if (ok !== 1'b1 || press_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL release: got lvl=%b v=%b ovf=%b expected 0000 0 0", btn_level, press_valid, overflow);
        end
    endtask

    task automatic test_glitch();
        logic [3:0] seen_lvl;
        logic       seen_v;
        seen_lvl = '0;
        seen_v   = 1'b0;
        btn_raw = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            seen_lvl |= btn_level; seen_v |= press_valid;
        end
        btn_raw = 4'b0000;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            seen_lvl |= btn_level; seen_v |= press_valid;
        end
        n_checks++;
        if (seen_lvl !== 4'b0000 || seen_v !== 1'b0) begin
            n_fail++; $display("FAIL glitch_filtered: got lvl=%b v=%b expected 0000 0", seen_lvl, seen_v);
        end
    endtask

    task automatic test_slot_busy();
        bit ok;
        btn_raw = 4'b0001;
        wait_level(4'b0001, ok);
        idle(2);
        n_checks++;
        if (ok !== 1'b1 || press_valid !== 1'b1 || press_idx !== 2'd0) begin
            n_fail++; $display("FAIL busy_first: got v=%b idx=%0d expected v=1 idx=0", press_valid, press_idx);
        end
        btn_raw = 4'b1001;
        wait_level(4'b1001, ok);
        idle(2);
        n_checks++;
        if (ok !== 1'b1 || press_valid !== 1'b1 || press_idx !== 2'd0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL busy_drop: got v=%b idx=%0d ovf=%b expected v=1 idx=0 ovf=1",
                               press_valid, press_idx, overflow);
        end
        consume();
        idle(2);
        n_checks++;
        if (press_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL busy_after_consume: got v=%b ovf=%b expected v=0 ovf=1", press_valid, overflow);
        end
        clear_ovf();
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
        btn_raw = 4'b0000;
        wait_level(4'b0000, ok);
    endtask

    task automatic test_multi_press();
        bit ok;
        btn_raw = 4'b1010;
        wait_level(4'b1010, ok);
        @(negedge clk);
        n_checks++;
        if (ok !== 1'b1 || press_valid !== 1'b1 || press_idx !== 2'd1 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL multi_press: got v=%b idx=%0d ovf=%b expected v=1 idx=1 ovf=1",
                               press_valid, press_idx, overflow);
        end
        consume();
        clear_ovf();
        btn_raw = 4'b0000;
        wait_level(4'b0000, ok);
        n_checks++;
        if (press_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL multi_cleanup: got v=%b ovf=%b expected 0 0", press_valid, overflow);
        end
    endtask

    task automatic test_accept_disabled();
        bit ok;
        accept_en = 1'b0;
        btn_raw = 4'b0001;
        wait_level(4'b0001, ok);
        idle(4);
        n_checks++;
        if (ok !== 1'b1 || press_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL accept_off: got lvl=%b v=%b ovf=%b expected 0001 0 0", btn_level, press_valid, overflow);
        end
        accept_en = 1'b1;
        idle(20);
        n_checks++;
        if (press_valid !== 1'b0) begin n_fail++; $display("FAIL held_through_turn: got %b expected 0", press_valid); end
        btn_raw = 4'b0000;
        wait_level(4'b0000, ok);
    endtask

    task automatic test_reset_mid_press();
        bit ok;
        btn_raw = 4'b0100;
        wait_level(4'b0100, ok);
        @(negedge clk);
        n_checks++;
        if (ok !== 1'b1 || press_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_setup: got v=%b expected 1", press_valid);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({press_valid, press_idx, btn_level, overflow} !== 8'h00) begin
            n_fail++; $display("FAIL rst_immediate: got %b expected 00000000",
                               {press_valid, press_idx, btn_level, overflow});
        end
        @(negedge clk);
        rst = 1'b0;
        wait_level(4'b0100, ok);
        @(negedge clk);
        n_checks++;
        if (ok !== 1'b1 || press_valid !== 1'b1 || press_idx !== 2'd2) begin
            n_fail++; $display("FAIL rst_repress: got v=%b idx=%0d expected v=1 idx=2", press_valid, press_idx);
        end
        consume();
        btn_raw = 4'b0000;
        wait_level(4'b0000, ok);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_slot_busy();
        test_multi_press();
        test_accept_disabled();
        test_reset_mid_press();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
